// File: rtl/timer_pkg.sv
// Shared register map, control/status bit positions and the byte-lane merge
// helper for the timer peripheral.
package timer_pkg;

  localparam logic [7:0] OFS_CTRL      = 8'h00;
  localparam logic [7:0] OFS_PRESC     = 8'h02;
  localparam logic [7:0] OFS_RELOAD_HI = 8'h04;
  localparam logic [7:0] OFS_RELOAD_LO = 8'h06;
  localparam logic [7:0] OFS_COUNT_HI  = 8'h08;
  localparam logic [7:0] OFS_COUNT_LO  = 8'h0A;
  localparam logic [7:0] OFS_STATUS    = 8'h0C;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int STATUS_EXP = 0;

  // Upper strobe selects bits [15:8], lower strobe selects bits [7:0].
  function automatic logic [15:0] laneMerge(input logic [15:0] oldVal,
                                            input logic [15:0] newVal,
                                            input logic        upper,
                                            input logic        lower);
    laneMerge = {upper ? newVal[15:8] : oldVal[15:8],
                 lower ? newVal[7:0]  : oldVal[7:0]};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler down-counter: emits one tick every (presc+1) enabled clocks.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_restart,
  input  logic [15:0] i_presc,
  output logic        o_tick
);

  logic [15:0] r_pcnt;

  // A restart reloads the count and swallows any tick due on that cycle.
  assign o_tick = i_en & ~i_restart & (r_pcnt == 16'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pcnt <= 16'd0;
    end else if (i_restart) begin
      r_pcnt <= i_presc;
    end else if (i_en) begin
      r_pcnt <= (r_pcnt == 16'd0) ? i_presc : r_pcnt - 16'd1;
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Programmable down-counting timer slave on the 16-bit peripheral bus.
// Define TIMER_LATCH_EN to add a COUNT_LO shadow latched by COUNT_HI reads.
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  input  logic [7:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  output logic        ack,
  output logic        irq
);

  localparam logic [31:0] CNT_MASK   = 32'hFFFF_FFFF >> (32 - CNT_WIDTH);
  localparam logic [15:0] PRESC_MASK = 16'hFFFF >> (16 - PRESC_WIDTH);

  logic [2:0]  r_ctrl;
  logic [15:0] r_presc;
  logic [31:0] r_reload;
  logic [31:0] r_count;
  logic        r_exp;
  logic        r_ack;
  logic [15:0] r_dataRead;
  logic        r_irq;

  logic        w_req, w_start, w_wr, w_rd;
  logic [7:0]  w_ofs;
  logic        w_wrCtrl, w_wrPresc, w_wrReloadHi, w_wrReloadLo;
  logic        w_wrCountHi, w_wrCountLo, w_wrCount, w_wrStatus;
  logic        w_enRise, w_enDrop, w_restart;
  logic        w_presTick, w_tick, w_setExp, w_clrExp;
  logic [15:0] w_countLoRead;
  logic [15:0] w_readVal;
  logic        w_unused;

  assign w_unused = addr[0];

  assign w_req   = uds | lds;
  assign w_start = w_req & ~r_ack;
  assign w_wr    = w_start & ~rw;
  assign w_rd    = w_start & rw;
  assign w_ofs   = {addr[7:1], 1'b0};

  assign w_wrCtrl     = w_wr && (w_ofs == OFS_CTRL);
  assign w_wrPresc    = w_wr && (w_ofs == OFS_PRESC);
  assign w_wrReloadHi = w_wr && (w_ofs == OFS_RELOAD_HI);
  assign w_wrReloadLo = w_wr && (w_ofs == OFS_RELOAD_LO);
  assign w_wrCountHi  = w_wr && (w_ofs == OFS_COUNT_HI);
  assign w_wrCountLo  = w_wr && (w_ofs == OFS_COUNT_LO);
  assign w_wrStatus   = w_wr && (w_ofs == OFS_STATUS);
  assign w_wrCount    = w_wrCountHi | w_wrCountLo;

  // CTRL bits live only in the lower lane, so only lds can change EN.
  assign w_enRise  = w_wrCtrl & lds & data_write[CTRL_EN] & ~r_ctrl[CTRL_EN];
  assign w_enDrop  = w_wrCtrl & lds & ~data_write[CTRL_EN];
  assign w_restart = w_enRise | w_wrCount;

  timer_prescaler u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (r_ctrl[CTRL_EN]),
    .i_restart (w_restart),
    .i_presc   (r_presc),
    .o_tick    (w_presTick)
  );

  assign w_tick   = w_presTick & ~w_enDrop;
  assign w_setExp = w_tick & (r_count == 32'd0);
  assign w_clrExp = w_wrStatus & lds & data_write[STATUS_EXP];

`ifdef TIMER_LATCH_EN
  logic [15:0] r_shadow;
  logic        r_shadowValid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shadow      <= 16'd0;
      r_shadowValid <= 1'b0;
    end else if (w_wrCount) begin
      r_shadowValid <= 1'b0;
    end else if (w_rd && (w_ofs == OFS_COUNT_HI)) begin
      r_shadow      <= r_count[15:0];
      r_shadowValid <= 1'b1;
    end else if (w_rd && (w_ofs == OFS_COUNT_LO)) begin
      r_shadowValid <= 1'b0;
    end
  end

  assign w_countLoRead = r_shadowValid ? r_shadow : r_count[15:0];
`else
  assign w_countLoRead = r_count[15:0];
`endif

  always_comb begin
    w_readVal = 16'd0;
    case (w_ofs)
      OFS_CTRL:      w_readVal = {13'd0, r_ctrl};
      OFS_PRESC:     w_readVal = r_presc;
      OFS_RELOAD_HI: w_readVal = r_reload[31:16];
      OFS_RELOAD_LO: w_readVal = r_reload[15:0];
      OFS_COUNT_HI:  w_readVal = r_count[31:16];
      OFS_COUNT_LO:  w_readVal = w_countLoRead;
      OFS_STATUS:    w_readVal = {15'd0, r_exp};
      default:       w_readVal = 16'd0;
    endcase
  end

  // Later assignments win: a bus write overrides the tick's effect on the
  // same register, and the set term in r_exp beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl     <= 3'd0;
      r_presc    <= 16'd0;
      r_reload   <= 32'd0;
      r_count    <= 32'd0;
      r_exp      <= 1'b0;
      r_ack      <= 1'b0;
      r_dataRead <= 16'd0;
      r_irq      <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_irq <= r_exp & r_ctrl[CTRL_IRQEN];
      r_exp <= (r_exp & ~w_clrExp) | w_setExp;

      if (w_start) begin
        r_dataRead <= rw ? w_readVal : 16'd0;
      end

      if (w_tick) begin
        if (r_count != 32'd0) begin
          r_count <= r_count - 32'd1;
        end else if (r_ctrl[CTRL_AUTO]) begin
          r_count <= r_reload;
        end else begin
          r_ctrl[CTRL_EN] <= 1'b0;
        end
      end

      if (w_wrCtrl && lds) begin
        r_ctrl <= data_write[2:0];
      end
      if (w_wrPresc) begin
        r_presc <= laneMerge(r_presc, data_write, uds, lds) & PRESC_MASK;
      end
      if (w_wrReloadHi) begin
        r_reload <= {laneMerge(r_reload[31:16], data_write, uds, lds),
                     r_reload[15:0]} & CNT_MASK;
      end
      if (w_wrReloadLo) begin
        r_reload <= {r_reload[31:16],
                     laneMerge(r_reload[15:0], data_write, uds, lds)} & CNT_MASK;
      end
      if (w_wrCountHi) begin
        r_count <= {laneMerge(r_count[31:16], data_write, uds, lds),
                    r_count[15:0]} & CNT_MASK;
      end
      if (w_wrCountLo) begin
        r_count <= {r_count[31:16],
                    laneMerge(r_count[15:0], data_write, uds, lds)} & CNT_MASK;
      end
    end
  end

  assign ack       = r_ack;
  assign data_read = r_dataRead;
  assign irq       = r_irq;

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Programmable 32-bit down-counting timer. It is a bus slave on the 16-bit CPU peripheral bus, occupying one device_mux slave slot next to uart, leds_dev and spi.
- Provides periodic or one-shot expiry with a level interrupt request. It is the source that drives the CPU interrupt priority inputs, which are currently tied inactive.
- Register file is 16 bits wide with byte-lane writes. It uses the same uds/lds/rw/ack slave protocol as the other peripherals.

Parameters:
- CNT_WIDTH, 32, counter and reload width. Split over HI/LO registers; upper bits beyond CNT_WIDTH read 0.
- PRESC_WIDTH, 16, prescaler width. Must be 16 or less.

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- data_write  in  16  write data. [15:8] is the uds lane, [7:0] is the lds lane.
- data_read  out  16  registered read data, valid while ack=1.
- addr  in  8  byte offset within the slave window. Bit 0 is ignored.
- uds  in  1  active-high upper byte strobe. The device is selected when uds or lds is high.
- lds  in  1  active-high lower byte strobe.
- rw  in  1  1 = read, 0 = write.
- ack  out  1  active-high transfer acknowledge.
- irq  out  1  registered level interrupt request.

Behaviour:
- Reset: all registers, prescaler, counter, ack, data_read and irq are 0.
- Bus handshake:
  - req = uds|lds.
  - Access starts on the cycle where req=1 and ack=0.
  - ack rises on the next clock and holds while req=1. It falls on the clock after req falls.
  - One register side effect per access, committed on the start cycle.
  - data_read is loaded on the start cycle.
  - Writes honour lanes: uds writes [15:8], lds writes [7:0].
  - Unmapped offsets read 0, ignore writes, and are still acked.
- Register map (byte offsets):
  - 0x00 CTRL: b0 EN, b1 AUTO (auto-reload), b2 IRQEN. Other bits read 0.
  - 0x02 PRESC.
  - 0x04 RELOAD_HI, 0x06 RELOAD_LO.
  - 0x08 COUNT_HI, 0x0A COUNT_LO. A write loads that half of the counter and resets the prescaler to PRESC.
  - 0x0C STATUS: b0 EXP. Writing 1 clears it; writing 0 has no effect.
- Prescaler:
  - When EN=1, pcnt decrements each clock.
  - At pcnt=0 it emits tick and reloads PRESC.
  - An EN 0->1 write reloads pcnt with PRESC.
  - With EN=0, pcnt and the counter are frozen.
- Counter, on tick:
  - If count≠0: count decrements.
  - If count=0: EXP is set. With AUTO=1, count is reloaded from RELOAD; with AUTO=0, EN is cleared and count stays 0.
  - Auto-reload period = (PRESC+1)*(RELOAD+1) clocks.
- irq is registered as EXP & IRQEN, i.e. one cycle after EXP or IRQEN changes.
- Simultaneous events:
  - Expiry and a STATUS clear in the same cycle: set wins, EXP stays 1.
  - A COUNT write and a tick in the same cycle: the write wins and the tick is dropped.
  - A CTRL write clearing EN during a tick: the tick is discarded.
- reset_n low mid-access: ack drops on the next clock. The access is lost, with no partial commit beyond the start-cycle write.

Optional Feature:
- Macro TIMER_LATCH_EN.
- When defined:
  - Reading COUNT_HI snapshots the current COUNT_LO into a shadow register.
  - The next COUNT_LO read returns the shadow.
  - Any COUNT write invalidates the shadow, so COUNT_LO reads live again.
- When undefined: COUNT_LO always reads the live counter and no shadow flop exists.

Decomposition:
- Package timer_pkg holds:
  - register offset constants: OFS_CTRL, OFS_PRESC, OFS_RELOAD_HI/LO, OFS_COUNT_HI/LO, OFS_STATUS;
  - CTRL bit indices CTRL_EN, CTRL_AUTO, CTRL_IRQEN, and STATUS_EXP.
- One sub-module, timer_prescaler, contains the pcnt down-counter with reload and restart inputs and a tick output.
- Bus decode, registers and the main counter stay in timer_dev.

Test Plan:
- Bus handshake: read 0x00 after reset with uds=lds=1 held 4 cycles -> ack=1 from cycle 2 through cycle 5 and 0 the cycle after the strobes drop, data_read=0x0000; a single write to 0x02 with strobes held 4 cycles commits exactly once.
- Lane writes: write 0x1234 to PRESC with uds only, then 0x5678 with lds only -> PRESC reads 0x1278.
- Auto-reload period: PRESC=1, RELOAD=3, COUNT=3, CTRL=0x0007 -> EXP and then irq (one clock later) assert 8 clocks after enable and every 8 clocks after. Writing STATUS=0x0001 drops irq one clock after the clear.
- One-shot: AUTO=0, PRESC=0, COUNT=2, EN=1 -> EXP after 3 ticks, CTRL reads 0x0000, COUNT stays 0, no further expiry.
- Collision: clear EXP on the exact cycle of the next expiry -> EXP remains 1. Write COUNT_LO=0x0005 on a tick cycle -> COUNT_LO reads 5.
- TIMER_LATCH_EN: counter at 0x0001_0000 with PRESC=0; read HI (0x0001), wait 3 clocks, read LO -> 0x0000 with the macro, 0xFFFD without it.
